// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with round-robin ownership, a forced idle gap
// between owners, and a watchdog that aborts slave cycles that never terminate.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic own0, own1, aborting;
  logic owner_cyc, owner_stb, slave_term;

  assign own0       = (state_q == OWN0);
  assign own1       = (state_q == OWN1);
  assign aborting   = (state_q == ABORT);
  assign owner_cyc  = own1 ? m1_cyc_i : m0_cyc_i;
  assign owner_stb  = own1 ? m1_stb_i : m0_stb_i;
  assign slave_term = s_ack_i | s_err_i | s_rty_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie the master that was not served last wins.
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (owner_stb && !slave_term) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ABORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      ABORT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_cyc_o = own0 ? m0_cyc_i : (own1 ? m1_cyc_i : 1'b0);
  assign s_stb_o = own0 ? m0_stb_i : (own1 ? m1_stb_i : 1'b0);
  assign s_we_o  = own0 ? m0_we_i  : (own1 ? m1_we_i  : 1'b0);
  assign s_adr_o = own0 ? m0_adr_i : (own1 ? m1_adr_i : '0);
  assign s_dat_o = own0 ? m0_dat_i : (own1 ? m1_dat_i : '0);
  assign s_sel_o = own0 ? m0_sel_i : (own1 ? m1_sel_i : '0);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // During ABORT last_q still names the owner; slave terminations are masked.
  assign m0_ack_o = own0 & s_ack_i;
  assign m0_rty_o = own0 & s_rty_i;
  assign m0_err_o = (own0 & s_err_i) | (aborting & ~last_q);
  assign m1_ack_o = own1 & s_ack_i;
  assign m1_rty_o = own1 & s_rty_i;
  assign m1_err_o = (own1 & s_err_i) | (aborting & last_q);

  assign grant_o   = {own1 | (aborting & last_q), own0 | (aborting & ~last_q)};
  assign timeout_o = aborting;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: cycle table for grant/routing sequences,
// plus hand-written watchdog and async-reset sequences.
module tb_wb_arbiter_2m;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
  localparam logic [AW-1:0] A0 = 32'h0000_0004;
  localparam logic [AW-1:0] A1 = 32'h0000_0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic m1_cyc = 0, m1_stb = 0, m1_we = 1;
  logic [AW-1:0] m0_adr = A0, m1_adr = A1;
  logic [DW-1:0] m0_dat = 32'h1111_0000, m1_dat = 32'h2222_0000;
  logic [SW-1:0] m0_sel = 4'hF, m1_sel = 4'h3;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat = 32'hDEAD_BEEF;
  logic s_ack = 0, s_err = 0, s_rty = 0;
  logic [1:0] grant_o;
  logic timeout_o;

  wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // exp = {grant, s_cyc, s_adr, m0 ack/err/rty, m1 ack/err/rty, timeout}
  typedef struct {
    bit r, c0, c1, ack, err, rty;
    logic [41:0] exp;
  } vec_t;

  vec_t vq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic vec_t mk(bit r, bit c0, bit c1, bit ack, bit err, bit rty,
                              logic [1:0] g, bit scyc, logic [AW-1:0] sadr, logic [6:0] terms);
    vec_t v;
    v.r = r; v.c0 = c0; v.c1 = c1; v.ack = ack; v.err = err; v.rty = rty;
    v.exp = {g, scyc, sadr, terms};
    return v;
  endfunction

  function automatic logic [41:0] observed();
    return {grant_o, s_cyc_o, s_adr_o, m0_ack_o, m0_err_o, m0_rty_o,
            m1_ack_o, m1_err_o, m1_rty_o, timeout_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_rty = 0;
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit x, a, e, q;
    // Single-master read after reset; slave acks on the third owned cycle.
    vq.push_back(mk(1, 0,0, 0,0,0, 2'b00, 0, '0, 7'b0));
    vq.push_back(mk(0, 1,0, 0,0,0, 2'b00, 0, '0, 7'b0));
    vq.push_back(mk(0, 1,0, 0,0,0, 2'b01, 1, A0, 7'b0));
    vq.push_back(mk(0, 1,0, 0,0,0, 2'b01, 1, A0, 7'b0));
    vq.push_back(mk(0, 1,0, 1,0,0, 2'b01, 1, A0, 7'b1000000));
    vq.push_back(mk(0, 0,0, 0,0,0, 2'b01, 0, A0, 7'b0));
    vq.push_back(mk(0, 0,0, 0,0,0, 2'b00, 0, '0, 7'b0));
    // Tie after reset: master 0 first, one idle cycle, then master 1.
    vq.push_back(mk(1, 0,0, 0,0,0, 2'b00, 0, '0, 7'b0));
    vq.push_back(mk(0, 1,1, 0,0,0, 2'b00, 0, '0, 7'b0));
    vq.push_back(mk(0, 1,1, 1,0,0, 2'b01, 1, A0, 7'b1000000));
    vq.push_back(mk(0, 0,1, 0,0,0, 2'b01, 0, A0, 7'b0));
    vq.push_back(mk(0, 0,1, 0,0,0, 2'b00, 0, '0, 7'b0));
    vq.push_back(mk(0, 0,1, 1,0,0, 2'b10, 1, A1, 7'b0001000));
    vq.push_back(mk(0, 0,0, 0,0,0, 2'b10, 0, A1, 7'b0));
    vq.push_back(mk(0, 0,0, 0,0,0, 2'b00, 0, '0, 7'b0));
    // Round robin with both masters requesting; a few err/rty terminations mixed in.
    for (int k = 0; k < 8; k++) begin
      x = k[0];
      e = (k == 3);
      q = (k == 4);
      a = !e && !q;
      vq.push_back(mk(0, 1,1, 0,0,0, 2'b00, 0, '0, 7'b0));
      vq.push_back(mk(0, 1,1, a,e,q, x ? 2'b10 : 2'b01, 1, x ? A1 : A0,
                      x ? {3'b000, a, e, q, 1'b0} : {a, e, q, 3'b000, 1'b0}));
      vq.push_back(mk(0, x,!x, 0,0,0, x ? 2'b10 : 2'b01, 0, x ? A1 : A0, 7'b0));
    end

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      tick();
      rst = vq[i].r;
      m0_cyc = vq[i].c0; m0_stb = vq[i].c0;
      m1_cyc = vq[i].c1; m1_stb = vq[i].c1;
      s_ack = vq[i].ack; s_err = vq[i].err; s_rty = vq[i].rty;
      #4;
      check($sformatf("row%0d", i), 64'(observed()), 64'(vq[i].exp));
      if (vq[i].ack) begin
        check($sformatf("row%0d_m0_dat", i), 64'(m0_dat_o), 64'h0000_0000_DEAD_BEEF);
        check($sformatf("row%0d_m1_dat", i), 64'(m1_dat_o), 64'h0000_0000_DEAD_BEEF);
      end
    end
    tick();
    rst = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_err = 0; s_rty = 0;

    // Watchdog: master 1 write, slave never responds.
    do_reset();
    tick(); m1_cyc = 1; m1_stb = 0;
    tick(); m1_stb = 1;
    #4;
    check("to_route", 64'({grant_o, s_we_o, s_sel_o, s_dat_o}), 64'({2'b10, 1'b1, 4'h3, 32'h2222_0000}));
    for (int i = 0; i < TMO; i++) begin
      if (i > 0) begin
        tick();
        #4;
      end
      check($sformatf("to_stall%0d", i), 64'({m1_err_o, timeout_o, s_cyc_o}), 64'(3'b001));
    end
    tick(); s_ack = 1; m0_cyc = 1; m0_stb = 1;
    #4;
    check("to_abort", 64'({grant_o, m1_err_o, timeout_o, s_cyc_o, s_stb_o, m1_ack_o, m0_err_o}),
          64'({2'b10, 6'b110000}));
    tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
    #4;
    check("to_idle", 64'({grant_o, s_cyc_o, timeout_o, m1_err_o}), 64'(5'b00000));
    tick();
    #4;
    check("to_m0_grant", 64'({grant_o, s_cyc_o, s_adr_o}), 64'({2'b01, 1'b1, A0}));
    tick(); m0_cyc = 0; m0_stb = 0;

    // Slave acks exactly on the threshold cycle: ack wins, no abort.
    do_reset();
    tick(); m0_cyc = 1; m0_stb = 0;
    tick(); m0_stb = 1;
    for (int i = 0; i < TMO - 1; i++) begin
      if (i > 0) tick();
      #4;
      check($sformatf("thr_stall%0d", i), 64'({m0_err_o, timeout_o, s_cyc_o}), 64'(3'b001));
    end
    tick(); s_ack = 1;
    #4;
    check("thr_ack", 64'({m0_ack_o, m0_err_o, timeout_o}), 64'(3'b100));
    tick(); s_ack = 0; m0_stb = 0;
    #4;
    check("thr_after", 64'({grant_o, s_cyc_o, m0_err_o, timeout_o}), 64'(5'b01100));
    tick(); m0_cyc = 0;

    // Asynchronous reset while master 1 owns with stb high.
    do_reset();
    tick(); m1_cyc = 1; m1_stb = 1;
    tick();
    #4;
    check("rst_pre", 64'({grant_o, s_cyc_o}), 64'(3'b101));
    #1 s_ack = 1;
    #1 rst = 1;
    #1;
    check("rst_async", 64'({s_cyc_o, s_stb_o, grant_o, m0_ack_o, m0_err_o, m0_rty_o,
                           m1_ack_o, m1_err_o, m1_rty_o, timeout_o}), 64'(0));
    tick(); rst = 0; s_ack = 0; m0_cyc = 1; m0_stb = 1;
    #4;
    check("rst_idle", 64'({grant_o, s_cyc_o}), 64'(3'b000));
    tick();
    #4;
    check("rst_tie_m0", 64'({grant_o, s_cyc_o, m1_ack_o}), 64'(4'b0110));
    tick(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
